// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and default widths for the data-RAM arbiter
package dmem_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKED,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_HOST
  } owner_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear and hold
module sat_counter #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         hold,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // hold dominates clear so a frozen count survives a cycle with no request
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= '0;
    end else if (!hold) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc && (cnt != MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data RAM between CPU and host ports
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = dmem_pkg::AW,
  parameter int DW       = dmem_pkg::DW,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          locked,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [3:0] WAIT_SAT  = 4'(MAX_WAIT);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  arb_state_t state;
  logic [3:0] wait_cnt;
  logic [7:0] lock_cnt;
  logic       rd_valid;
  owner_t     rd_owner;

  // grants are gated by clrn so nothing reaches the RAM while in reset
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (clrn) begin
      case (state)
        UNLOCKED: begin
          host_gnt = host_req && (!cpu_req || (wait_cnt == WAIT_SAT));
          cpu_gnt  = cpu_req && !host_gnt;
        end
        LOCKED:   host_gnt = host_req;
        RELEASE:  cpu_gnt  = cpu_req;
        default: ;
      endcase
    end
  end

  assign ram_en = cpu_gnt | host_gnt;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (host_gnt) begin
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end else if (cpu_gnt) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end
  end

  sat_counter #(
    .W   (4),
    .MAX (WAIT_SAT)
  ) u_wait_cnt (
    .clk  (clk),
    .clrn (clrn),
    .hold (state == RELEASE),
    .clr  (host_gnt || !host_req),
    .inc  (host_req && !host_gnt),
    .cnt  (wait_cnt)
  );

  sat_counter #(
    .W   (8),
    .MAX (LOCK_LAST)
  ) u_lock_cnt (
    .clk  (clk),
    .clrn (clrn),
    .hold (1'b0),
    .clr  (state != LOCKED),
    .inc  (state == LOCKED),
    .cnt  (lock_cnt)
  );

  // a dropped lock wins over expiry in the same cycle
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= UNLOCKED;
      locked <= 1'b0;
    end else begin
      case (state)
        UNLOCKED: begin
          if (host_gnt && host_lock) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (!host_lock) begin
            state  <= UNLOCKED;
            locked <= 1'b0;
          end else if (lock_cnt == LOCK_LAST) begin
            state  <= RELEASE;
            locked <= 1'b0;
          end
        end
        RELEASE: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
        default: begin
          state  <= UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd_valid <= 1'b0;
      rd_owner <= OWN_CPU;
    end else begin
      rd_valid <= ram_en && !ram_we;
      rd_owner <= host_gnt ? OWN_HOST : OWN_CPU;
    end
  end

  assign cpu_rvalid  = rd_valid && (rd_owner == OWN_CPU);
  assign host_rvalid = rd_valid && (rd_owner == OWN_HOST);
  assign cpu_rdata   = cpu_rvalid  ? ram_rdata : '0;
  assign host_rdata  = host_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter with a reference model
module tb_dmem_arbiter;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int LOCK_MAX = 8;

  logic          clk, clrn;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          locked, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  dmem_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .clrn(clrn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .locked(locked), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the RAM itself: synchronous write, one-cycle registered read
  logic          ram_clear;
  logic [DW-1:0] ram [32];
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 32; i++) ram[i] <= '0;
      ram_rdata <= '0;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  int          total, bad;
  int          m_mode, m_wait, m_lockcyc;
  logic        m_rv_c, m_rv_h;
  logic [31:0] m_rd;
  logic [31:0] ref_mem [32];
  logic        last_cg, last_hg;
  logic        obs_cg, obs_hg, obs_locked, obs_crv, obs_hrv;
  logic [31:0] obs_crd, obs_hrd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    m_mode = 0; m_wait = 0; m_lockcyc = 0;
    m_rv_c = 1'b0; m_rv_h = 1'b0; m_rd = '0;
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_host(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                          input logic lk);
    host_req = r; host_we = w; host_addr = a; host_wdata = d; host_lock = lk;
  endtask

  // one clock: check outputs mid-cycle against the model, then advance the model at the edge
  task automatic step();
    logic        ecg, ehg, we;
    logic [4:0]  a;
    logic [31:0] wd;
    @(negedge clk);
    ecg = 1'b0; ehg = 1'b0;
    if (m_mode == 0) begin
      ehg = host_req && (!cpu_req || (m_wait == MAX_WAIT));
      ecg = cpu_req && !ehg;
    end else if (m_mode == 1) begin
      ehg = host_req;
    end else begin
      ecg = cpu_req;
    end
    a  = ehg ? host_addr  : (ecg ? cpu_addr  : 5'd0);
    we = ehg ? host_we    : (ecg ? cpu_we    : 1'b0);
    wd = ehg ? host_wdata : (ecg ? cpu_wdata : 32'd0);
    obs_cg = cpu_gnt; obs_hg = host_gnt; obs_locked = locked;
    obs_crv = cpu_rvalid; obs_hrv = host_rvalid; obs_crd = cpu_rdata; obs_hrd = host_rdata;
    chk("cpu_gnt",     32'(cpu_gnt),     32'(ecg));
    chk("host_gnt",    32'(host_gnt),    32'(ehg));
    chk("ram_en",      32'(ram_en),      32'(ecg | ehg));
    chk("ram_we",      32'(ram_we),      32'(we));
    chk("ram_addr",    32'(ram_addr),    32'(a));
    chk("ram_wdata",   ram_wdata,        wd);
    chk("locked",      32'(locked),      32'(m_mode == 1));
    chk("cpu_rvalid",  32'(cpu_rvalid),  32'(m_rv_c));
    chk("host_rvalid", 32'(host_rvalid), 32'(m_rv_h));
    chk("cpu_rdata",   cpu_rdata,        m_rv_c ? m_rd : 32'd0);
    chk("host_rdata",  host_rdata,       m_rv_h ? m_rd : 32'd0);
    @(posedge clk);
    m_rv_c = ecg && !cpu_we;
    m_rv_h = ehg && !host_we;
    if ((ecg || ehg) && !we) m_rd = ref_mem[a];
    if ((ecg || ehg) && we)  ref_mem[a] = wd;
    if (m_mode != 2) begin
      if (host_req && !ehg) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else                  m_wait = 0;
    end
    case (m_mode)
      0: if (ehg && host_lock) begin m_mode = 1; m_lockcyc = 1; end
      1: begin
        if (!host_lock)                 m_mode = 0;
        else if (m_lockcyc == LOCK_MAX) m_mode = 2;
        else                            m_lockcyc++;
      end
      default: m_mode = 0;
    endcase
    last_cg = ecg; last_hg = ehg;
    #1;
  endtask

  initial begin
    int   n;
    logic got, after;
    total = 0; bad = 0;
    last_cg = 1'b0; last_hg = 1'b0;
    reset_model();
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;

    // reset with both requests high: grants must stay forced low
    clrn = 1'b0; ram_clear = 1'b1;
    set_cpu(1'b1, 1'b1, 5'd1, 32'h1); set_host(1'b1, 1'b1, 5'd2, 32'h2, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_gnt",  32'(cpu_gnt),     0);
    chk("rst_host_gnt", 32'(host_gnt),    0);
    chk("rst_ram_en",   32'(ram_en),      0);
    chk("rst_ram_we",   32'(ram_we),      0);
    chk("rst_locked",   32'(locked),      0);
    chk("rst_crv",      32'(cpu_rvalid),  0);
    chk("rst_hrv",      32'(host_rvalid), 0);
    chk("rst_crd",      cpu_rdata,        0);
    chk("rst_hrd",      host_rdata,       0);
    set_cpu(1'b0, 1'b0, 5'd0, 32'd0); set_host(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    clrn = 1'b1; ram_clear = 1'b0;
    step();

    // CPU read of word 3 after the host loads 0x2A there
    set_host(1'b1, 1'b1, 5'd3, 32'h2A, 1'b0);
    step();
    chk("t1_load_gnt", 32'(obs_hg), 1);
    set_host(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    set_cpu(1'b1, 1'b0, 5'd3, 32'd0);
    step();
    chk("t1_cpu_gnt", 32'(obs_cg), 1);
    set_cpu(1'b0, 1'b0, 5'd0, 32'd0);
    step();
    chk("t1_cpu_rvalid",  32'(obs_crv), 1);
    chk("t1_cpu_rdata",   obs_crd,      32'h2A);
    chk("t1_host_rvalid", 32'(obs_hrv), 0);

    // starvation bound: host granted on every fifth cycle
    set_cpu(1'b1, 1'b1, 5'd1, 32'h11); set_host(1'b1, 1'b1, 5'd2, 32'h22, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t2_host_gnt", 32'(obs_hg), 32'((i % 5) == 4));
    end
    set_cpu(1'b0, 1'b0, 5'd0, 32'd0); set_host(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    step();

    // host lock burst over words 0..3 against a persistent CPU request
    set_cpu(1'b1, 1'b0, 5'd9, 32'd0);
    after = 1'b0;
    for (int a = 0; a < 4; a++) begin
      set_host(1'b1, 1'b1, 5'(a), $urandom, 1'b1);
      n = 0; got = 1'b0;
      while (!got && n < 10) begin
        step();
        n++;
        got = last_hg;
        if (after) begin
          chk("t3_locked",  32'(obs_locked), 1);
          chk("t3_cpu_gnt", 32'(obs_cg),     0);
        end
      end
      chk("t3_host_grant", 32'(got), 1);
      after = 1'b1;
    end
    set_host(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    chk("t3_drop_locked", 32'(obs_locked), 1);
    chk("t3_drop_cgnt",   32'(obs_cg),     0);
    step();
    chk("t3_cpu_after",   32'(obs_cg),     1);
    set_cpu(1'b0, 1'b0, 5'd0, 32'd0);
    step();

    // lock expiry: eight locked cycles, one release cycle, then host wins again
    set_cpu(1'b1, 1'b0, 5'd10, 32'd0); set_host(1'b1, 1'b1, 5'd20, $urandom, 1'b1);
    n = 0; got = 1'b0;
    while (!got && n < 10) begin step(); n++; got = last_hg; end
    chk("t4_first_grant", 32'(got), 1);
    for (int i = 0; i < LOCK_MAX; i++) begin
      step();
      chk("t4_locked",   32'(obs_locked), 1);
      chk("t4_cgnt_lck", 32'(obs_cg),     0);
    end
    step();
    chk("t4_rel_locked", 32'(obs_locked), 0);
    chk("t4_rel_cgnt",   32'(obs_cg),     1);
    chk("t4_rel_hgnt",   32'(obs_hg),     0);
    n = 0; got = 1'b0;
    while (!got && n < MAX_WAIT + 2) begin step(); n++; got = last_hg; end
    chk("t4_regain", 32'(got), 1);
    set_cpu(1'b0, 1'b0, 5'd0, 32'd0); set_host(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    step();

    // CPU write followed directly by a host read of the same word
    set_cpu(1'b1, 1'b1, 5'd7, 32'h55);
    step();
    chk("t6_cpu_gnt", 32'(obs_cg), 1);
    set_cpu(1'b0, 1'b0, 5'd0, 32'd0); set_host(1'b1, 1'b0, 5'd7, 32'd0, 1'b0);
    step();
    chk("t6_host_gnt", 32'(obs_hg), 1);
    set_host(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    step();
    chk("t6_host_rvalid", 32'(obs_hrv), 1);
    chk("t6_host_rdata",  obs_hrd,      32'h55);

    // reset pulse between a host read grant and its data return
    set_host(1'b1, 1'b0, 5'd5, 32'd0, 1'b0);
    @(negedge clk);
    chk("t5_host_gnt", 32'(host_gnt), 1);
    #2 clrn = 1'b0;
    #1;
    chk("t5_rst_hgnt",   32'(host_gnt),    0);
    chk("t5_rst_ram_en", 32'(ram_en),      0);
    chk("t5_rst_hrv",    32'(host_rvalid), 0);
    chk("t5_rst_locked", 32'(locked),      0);
    set_host(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    clrn = 1'b1;
    reset_model();
    step();
    chk("t5_hrv_after", 32'(obs_hrv), 0);

    // random traffic: requests held until granted, lock toggled at random
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!cpu_req && $urandom_range(0, 2) != 0)
        set_cpu(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      if (!host_req && $urandom_range(0, 3) == 0)
        set_host(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, host_lock);
      if ($urandom_range(0, 7) == 0) host_lock = ~host_lock;
      step();
      if (last_cg) cpu_req = 1'b0;
      if (last_hg) host_req = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
